arr_port_arbiter: RTL and testbench

ARR_PORT_ARBITER -- requirements
Module: arr_port_arbiter

---
 rtl/arr_port_arbiter_pkg.sv | 21 ++
 rtl/arr_port_arbiter_mem.sv | 40 ++++
 rtl/arr_port_arbiter.sv | 174 +++++++++++++++++
 tb/tb_arr_port_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/arr_port_arbiter_pkg.sv
// Shared constants and types for the two-requester array-port arbiter.
package arr_port_arbiter_pkg;

    localparam int DEF_DEPTH  = 1000;
    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 27;

    localparam int WDOG_LIMIT = 16;
    localparam int WDOG_W     = 5;

    typedef enum logic [1:0] {
        ST_FREE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } owner_e;

    localparam logic [1:0] TAG_NONE = 2'd0;
    localparam logic [1:0] TAG_0    = 2'd1;
    localparam logic [1:0] TAG_1    = 2'd2;

endpackage

// File: rtl/arr_port_arbiter_mem.sv
// Single-port word array: write at the clock edge, registered read address,
// combinational array read.
module arr_mem
    import arr_port_arbiter_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        addr,
    input  logic signed [DATA_W-1:0] wdata,
    output logic signed [DATA_W-1:0] rdata
);

    logic signed [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]        raddr_r;

    // array write; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    // read address capture for the next-cycle response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raddr_r <= {ADDR_W{1'b0}};
        end else if (en && !we) begin
            raddr_r <= addr;
        end
    end

    assign rdata = mem[raddr_r];

endmodule

// File: rtl/arr_port_arbiter.sv
// Arbitrates one shared array memory between a host (requester 0) and a kernel
// (requester 1) with lockable ownership and an idle watchdog.
module arr_port_arbiter
    import arr_port_arbiter_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_0,
    input  logic                     we_0,
    input  logic [ADDR_W-1:0]        addr_0,
    input  logic signed [DATA_W-1:0] wdata_0,
    input  logic                     lock_0,
    output logic                     gnt_0,
    output logic                     rvalid_0,
    output logic signed [DATA_W-1:0] rdata_0,
    output logic                     err_0,
    input  logic                     req_1,
    input  logic                     we_1,
    input  logic [ADDR_W-1:0]        addr_1,
    input  logic signed [DATA_W-1:0] wdata_1,
    input  logic                     lock_1,
    output logic                     gnt_1,
    output logic                     rvalid_1,
    output logic signed [DATA_W-1:0] rdata_1,
    output logic                     err_1,
    output logic [1:0]               owner
);

    owner_e              state_r, state_nxt;
    logic                last_r, last_nxt;
    logic [WDOG_W-1:0]   wdog_r, wdog_nxt;
    logic [1:0]          rsp_tag_r;
    logic                rsp_rd_r;
    logic                rsp_err_r;

    logic                any_gnt_s;
    logic                sel_we_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic signed [DATA_W-1:0] sel_wdata_s;
    logic                in_range_s;
    logic                mem_en_s;
    logic signed [DATA_W-1:0] mem_rdata_s;

    // grant decision and owner FSM next state
    always_comb begin
        gnt_0     = 1'b0;
        gnt_1     = 1'b0;
        state_nxt = state_r;
        wdog_nxt  = {WDOG_W{1'b0}};
        last_nxt  = last_r;
        if (!rst_n) begin
            state_nxt = ST_FREE;
        end else begin
            case (state_r)
                ST_FREE: begin
                    if (req_0 && req_1) begin
                        gnt_0 = last_r;
                        gnt_1 = !last_r;
                    end else begin
                        gnt_0 = req_0;
                        gnt_1 = req_1;
                    end
                    if (gnt_0 && lock_0) begin
                        state_nxt = ST_OWN0;
                    end else if (gnt_1 && lock_1) begin
                        state_nxt = ST_OWN1;
                    end else begin
                        state_nxt = ST_FREE;
                    end
                end
                ST_OWN0: begin
                    gnt_0 = req_0;
                    if (req_0) begin
                        state_nxt = lock_0 ? ST_OWN0 : ST_FREE;
                    end else if (wdog_r == WDOG_W'(WDOG_LIMIT - 1)) begin
                        state_nxt = ST_FREE;
                    end else begin
                        wdog_nxt = wdog_r + {{(WDOG_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_OWN1: begin
                    gnt_1 = req_1;
                    if (req_1) begin
                        state_nxt = lock_1 ? ST_OWN1 : ST_FREE;
                    end else if (wdog_r == WDOG_W'(WDOG_LIMIT - 1)) begin
                        state_nxt = ST_FREE;
                    end else begin
                        wdog_nxt = wdog_r + {{(WDOG_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_nxt = ST_FREE;
                end
            endcase
            if (gnt_0) begin
                last_nxt = 1'b0;
            end else if (gnt_1) begin
                last_nxt = 1'b1;
            end else begin
                last_nxt = last_r;
            end
        end
    end

    // owner FSM, last-winner flag and watchdog registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_FREE;
            last_r  <= 1'b1;
            wdog_r  <= {WDOG_W{1'b0}};
        end else begin
            state_r <= state_nxt;
            last_r  <= last_nxt;
            wdog_r  <= wdog_nxt;
        end
    end

    assign any_gnt_s   = gnt_0 | gnt_1;
    assign sel_we_s    = gnt_1 ? we_1    : (gnt_0 & we_0);
    assign sel_addr_s  = gnt_1 ? addr_1  : addr_0;
    assign sel_wdata_s = gnt_1 ? wdata_1 : wdata_0;
    assign in_range_s  = ({1'b0, sel_addr_s} < (ADDR_W+1)'(DEPTH));
    assign mem_en_s    = any_gnt_s & in_range_s;

    arr_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (mem_en_s),
        .we    (sel_we_s),
        .addr  (sel_addr_s),
        .wdata (sel_wdata_s),
        .rdata (mem_rdata_s)
    );

    // response tag: routes next-cycle responses independent of later FSM moves
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_tag_r <= TAG_NONE;
            rsp_rd_r  <= 1'b0;
            rsp_err_r <= 1'b0;
        end else begin
            rsp_tag_r <= gnt_1 ? TAG_1 : (gnt_0 ? TAG_0 : TAG_NONE);
            rsp_rd_r  <= any_gnt_s & !sel_we_s;
            rsp_err_r <= any_gnt_s & !in_range_s;
        end
    end

    assign rvalid_0 = rsp_rd_r  && (rsp_tag_r == TAG_0);
    assign rvalid_1 = rsp_rd_r  && (rsp_tag_r == TAG_1);
    assign err_0    = rsp_err_r && (rsp_tag_r == TAG_0);
    assign err_1    = rsp_err_r && (rsp_tag_r == TAG_1);
    assign rdata_0  = (rvalid_0 && !rsp_err_r) ? mem_rdata_s : {DATA_W{1'b0}};
    assign rdata_1  = (rvalid_1 && !rsp_err_r) ? mem_rdata_s : {DATA_W{1'b0}};

    // debug owner encoding
    always_comb begin
        owner = 2'd0;
        case (state_r)
            ST_FREE: owner = 2'd0;
            ST_OWN0: owner = 2'd1;
            ST_OWN1: owner = 2'd2;
            default: owner = 2'd0;
        endcase
    end

endmodule

// File: tb/tb_arr_port_arbiter.sv
// Directed bench for arr_port_arbiter with hand-computed expectations.
module tb_arr_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_0, we_0, lock_0, req_1, we_1, lock_1;
    logic [9:0]  addr_0, addr_1;
    logic signed [26:0] wdata_0, wdata_1, rdata_0, rdata_1;
    logic        gnt_0, gnt_1, rvalid_0, rvalid_1, err_0, err_1;
    logic [1:0]  owner;

    int tests = 0;
    int fails = 0;

    arr_port_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req_0(req_0), .we_0(we_0), .addr_0(addr_0), .wdata_0(wdata_0), .lock_0(lock_0),
        .gnt_0(gnt_0), .rvalid_0(rvalid_0), .rdata_0(rdata_0), .err_0(err_0),
        .req_1(req_1), .we_1(we_1), .addr_1(addr_1), .wdata_1(wdata_1), .lock_1(lock_1),
        .gnt_1(gnt_1), .rvalid_1(rvalid_1), .rdata_1(rdata_1), .err_1(err_1),
        .owner(owner)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chko(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chkd(input string tag, input logic signed [26:0] obs, input int exp);
        tests++;
        assert (obs === 27'(exp)) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // apply one cycle of requests just after the edge; checks follow at +3
    task automatic drive(input logic r0, input logic w0, input int a0, input int d0, input logic l0,
                         input logic r1, input logic w1, input int a1, input int d1, input logic l1);
        @(posedge clk);
        #1;
        req_0 = r0; we_0 = w0; addr_0 = 10'(a0); wdata_0 = 27'(d0); lock_0 = l0;
        req_1 = r1; we_1 = w1; addr_1 = 10'(a1); wdata_1 = 27'(d1); lock_1 = l1;
        #2;
    endtask

    initial begin
        rst_n = 1'b0;
        req_0 = 1'b1; we_0 = 1'b0; addr_0 = 10'd0; wdata_0 = 27'sd0; lock_0 = 1'b0;
        req_1 = 1'b1; we_1 = 1'b0; addr_1 = 10'd0; wdata_1 = 27'sd0; lock_1 = 1'b0;
        #3;
        chk1("rst_gnt0", gnt_0, 1'b0);
        chk1("rst_gnt1", gnt_1, 1'b0);
        chko("rst_owner", owner, 2'd0);
        chk1("rst_rvalid0", rvalid_0, 1'b0);
        chk1("rst_err1", err_1, 1'b0);
        chkd("rst_rdata0", rdata_0, 0);
        repeat (2) @(posedge clk);
        #1;
        req_0 = 1'b0; req_1 = 1'b0;
        rst_n = 1'b1;

        // host write 123 @5 then read it back
        drive(1, 1, 5, 123, 0, 0, 0, 0, 0, 0);
        chk1("wr5_gnt0", gnt_0, 1'b1);
        drive(1, 0, 5, 0, 0, 0, 0, 0, 0, 0);
        chk1("rd5_gnt0", gnt_0, 1'b1);
        chk1("wr5_no_rvalid", rvalid_0, 1'b0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk1("rd5_rvalid0", rvalid_0, 1'b1);
        chkd("rd5_rdata0", rdata_0, 123);
        chk1("rd5_err0", err_0, 1'b0);

        // preload addresses 0..3 and 7; the kernel write leaves last-winner = 1
        for (int i = 0; i < 4; i++) drive(1, 1, i, 10 + i, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 1, 7, -5, 0);
        chk1("kwr_gnt1", gnt_1, 1'b1);

        // both read every cycle: grants alternate, responses follow their tag
        drive(1, 0, 1, 0, 0, 1, 0, 7, 0, 0);
        chk1("alt_a_gnt0", gnt_0, 1'b1);
        chk1("alt_a_gnt1", gnt_1, 1'b0);
        drive(1, 0, 1, 0, 0, 1, 0, 7, 0, 0);
        chk1("alt_b_gnt1", gnt_1, 1'b1);
        chk1("alt_b_gnt0", gnt_0, 1'b0);
        chk1("alt_b_rvalid0", rvalid_0, 1'b1);
        chkd("alt_b_rdata0", rdata_0, 11);
        chk1("alt_b_rvalid1", rvalid_1, 1'b0);
        drive(1, 0, 1, 0, 0, 1, 0, 7, 0, 0);
        chk1("alt_c_gnt0", gnt_0, 1'b1);
        chk1("alt_c_rvalid1", rvalid_1, 1'b1);
        chkd("alt_c_rdata1", rdata_1, -5);
        chk1("alt_c_rvalid0", rvalid_0, 1'b0);
        chkd("alt_c_rdata0", rdata_0, 0);
        drive(1, 0, 1, 0, 0, 1, 0, 7, 0, 0);
        chk1("alt_d_gnt1", gnt_1, 1'b1);
        chkd("alt_d_rdata0", rdata_0, 11);
        drive(1, 0, 1, 0, 0, 1, 0, 7, 0, 0);
        chk1("alt_e_gnt0", gnt_0, 1'b1);
        chkd("alt_e_rdata1", rdata_1, -5);

        // kernel locked burst 0..3 then an unlocked access; host keeps requesting
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 2, 0, 0, 1, 0, i % 4, 0, (i < 4) ? 1'b1 : 1'b0);
            chk1("lock_gnt0_low", gnt_0, 1'b0);
            chk1("lock_gnt1", gnt_1, 1'b1);
            if (i == 0) begin
                chkd("lock_e_rdata0", rdata_0, 11);
            end else begin
                chkd("lock_rdata1", rdata_1, 10 + i - 1);
                chko("lock_owner", owner, 2'd2);
            end
        end
        drive(1, 0, 2, 0, 0, 0, 0, 0, 0, 0);
        chk1("unlock_gnt0", gnt_0, 1'b1);
        chko("unlock_owner", owner, 2'd0);
        chkd("unlock_rdata1", rdata_1, 10);

        // kernel locks then goes idle: watchdog frees the port after 16 cycles
        drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
        chk1("wd_lock_gnt1", gnt_1, 1'b1);
        chkd("wd_rdata0", rdata_0, 12);
        for (int i = 0; i < 16; i++) begin
            drive(1, 0, 3, 0, 0, 0, 0, 0, 0, 0);
            chk1("wd_idle_gnt0", gnt_0, 1'b0);
            chko("wd_idle_owner", owner, 2'd2);
        end
        drive(1, 0, 3, 0, 0, 0, 0, 0, 0, 0);
        chk1("wd_free_gnt0", gnt_0, 1'b1);
        chko("wd_free_owner", owner, 2'd0);

        // out-of-range read and write
        drive(1, 0, 1000, 0, 0, 0, 0, 0, 0, 0);
        chk1("oor_rd_gnt0", gnt_0, 1'b1);
        chkd("wd_free_rdata0", rdata_0, 13);
        drive(1, 1, 1023, 999, 0, 0, 0, 0, 0, 0);
        chk1("oor_rd_err0", err_0, 1'b1);
        chk1("oor_rd_rvalid0", rvalid_0, 1'b1);
        chkd("oor_rd_rdata0", rdata_0, 0);
        drive(1, 0, 5, 0, 0, 0, 0, 0, 0, 0);
        chk1("oor_wr_err0", err_0, 1'b1);
        chk1("oor_wr_rvalid0", rvalid_0, 1'b0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk1("post_oor_rvalid0", rvalid_0, 1'b1);
        chkd("post_oor_rdata0", rdata_0, 123);
        chk1("post_oor_err0", err_0, 1'b0);

        // reset mid-burst in OWN1 with a read outstanding
        drive(0, 0, 0, 0, 0, 1, 0, 1, 0, 1);
        chk1("rb_gnt1", gnt_1, 1'b1);
        drive(0, 0, 0, 0, 0, 1, 0, 2, 0, 1);
        chko("rb_owner", owner, 2'd2);
        chkd("rb_rdata1", rdata_1, 11);
        drive(0, 0, 0, 0, 0, 1, 0, 3, 0, 1);
        chkd("rb_rdata1b", rdata_1, 12);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chko("rb_rst_owner", owner, 2'd0);
        chk1("rb_rst_rvalid1", rvalid_1, 1'b0);
        chkd("rb_rst_rdata1", rdata_1, 0);
        chk1("rb_rst_gnt1", gnt_1, 1'b0);
        @(posedge clk);
        #1;
        req_1 = 1'b0; lock_1 = 1'b0;
        rst_n = 1'b1;
        #2;
        chk1("rb_rel_rvalid1", rvalid_1, 1'b0);
        drive(1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        chk1("rb_tie_gnt0", gnt_0, 1'b1);
        chk1("rb_tie_gnt1", gnt_1, 1'b0);
        chk1("rb_tie_rvalid1", rvalid_1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
